shift_reg_piso: RTL
===================

// Module: shift_reg_piso
// PURPOSE
//  Parallel-in serial-out transmitter: the sending end of the SIPO serial link.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clk.
//  Bit order matches a SIPO that shifts in at LSB: after WIDTH sampling edges its q equals the sent word.
//  Sits between a parallel producer (register/FIFO) and the serial wire feeding the SIPO.
// PARAMETERS
//  WIDTH  4  data word width in bits; legal range WIDTH >= 2
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  reset_n     in   1      asynchronous, active-low reset
//  load_valid  in   1      producer has a word on din
//  din         in   WIDTH  parallel word; sampled only on an accepted load
//  load_ready  out  1      transmitter can accept a word this cycle
//  sdo         out  1      serial data out
//  sdo_valid   out  1      sdo carries a frame bit this cycle
//  last        out  1      current sdo bit is the final bit of the frame
//  busy        out  1      frame in progress (state SHIFT)
// BEHAVIOUR
//  - Reset (asserted, async): state IDLE, shift reg=0, bit counter=0.
//    Outputs: sdo=0, sdo_valid=0, last=0, busy=0, load_ready=1.
//  - States: IDLE, SHIFT.
//  - Accept: posedge with load_valid && load_ready.
//    Effect: sreg<=din, cnt<=FRAME-1, state<=SHIFT.
//  - FRAME = WIDTH (WIDTH+1 with the parity option).
//    cnt width = $clog2(FRAME+1).
//  - IDLE: sdo=0, sdo_valid=0, last=0, busy=0, load_ready=1.
//  - SHIFT outputs:
//    - sdo=sreg[WIDTH-1], sdo_valid=1, busy=1.
//    - last=(cnt==0).
//    - load_ready=(cnt==0); it is high only on the final bit.
//  - SHIFT at each posedge:
//    - cnt!=0: sreg<=sreg<<1, zero fill; cnt<=cnt-1.
//    - cnt==0 with accept: reload as above. Back-to-back frames have no idle gap.
//    - cnt==0 without accept: state<=IDLE, sreg<=0.
//  - Latency: accept at edge k. Bit i (MSB=i=0) is driven between edges k+i and k+i+1.
//    A SIPO on the same clk holds the full word after edge k+WIDTH.
//  - load_valid while load_ready=0: ignored, no side effect. din needs to be stable only at the accept edge.
//  - All outputs are derived from registered state only. No combinational path from load_valid/din to sdo.
//  - Reset mid-frame: frame aborted at once; outputs take reset values and the partial word is discarded.
//  - Ownership: load_ready is a pure function of state. The producer owns load_valid and may hold it across cycles.
// CONFIGURATION
//  - Macro PISO_PARITY_EN defined:
//    - One extra bit follows the WIDTH data bits: even parity = ^din of the accepted word, captured at accept.
//    - FRAME=WIDTH+1. last and load_ready assert on the parity bit, not on data bit WIDTH-1.
//  - PISO_PARITY_EN undefined:
//    - No parity register. FRAME=WIDTH. last is on data LSB.
// TESTING
//  All cases use WIDTH=4, with a SIPO instance looped back on sdo for checking.
//  1. Reset release, no load_valid for 5 cycles -> load_ready=1, sdo=0, sdo_valid=0, busy=0, last=0 throughout.
//  2. Load 4'b1011 for one cycle -> sdo=1,0,1,1 on the next 4 cycles; sdo_valid=1 x4; last only on the 4th bit.
//     Then IDLE, and SIPO q=4'b1011.
//  3. Hold load_valid high with 4'b1011, then 4'b0110 presented on the last-bit cycle.
//     -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; no gap; SIPO q=4'b0110 at the end.
//  4. Pulse load_valid with 4'b0000 on the 2nd bit of a 4'b1111 frame.
//     -> ignored; output 1,1,1,1 then IDLE.
//  5. Assert reset_n=0 mid-edge during the 3rd bit of 4'b1010 -> sdo=0, sdo_valid=0, load_ready=1 immediately.
//     After release, 4'b0101 is sent cleanly.
//  6. PISO_PARITY_EN defined, load 4'b1011 -> 5 bits 1,0,1,1,1; last on the 5th.
//     Load 4'b1001 -> parity bit 0.

Source files
------------

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake and shifts it out MSB first.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit after the data bits.
module shift_reg_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             last,
  output logic             busy
);

  // Handshake: a word is taken on any posedge where load_valid && load_ready.
  // load_ready depends only on registered state; load_valid may be held by the producer.
`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cnt_zero;
  logic             accept;
  logic             frame_bit;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  always_comb begin
    cnt_zero   = (cnt_q == '0);
    busy       = (state_q == SHIFT);
    sdo_valid  = busy;
    last       = busy && cnt_zero;
    load_ready = !busy || cnt_zero;
`ifdef PISO_PARITY_EN
    // The final frame slot carries the parity captured at accept.
    frame_bit  = cnt_zero ? par_q : sreg_q[WIDTH-1];
`else
    frame_bit  = sreg_q[WIDTH-1];
`endif
    sdo        = busy ? frame_bit : 1'b0;
    accept     = load_valid && load_ready;
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      sreg_d  = din;
      cnt_d   = CW'(FRAME - 1);
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end else if (state_q == SHIFT) begin
      if (!cnt_zero) begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
      end else begin
        state_d = IDLE;
        sreg_d  = '0;
`ifdef PISO_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
